// File: rtl/mem_wait_ctrl.sv
// mem_wait_ctrl: GBA-style bus wait-state generator.
// Decodes the region of each accepted CPU access and classifies the access as
// sequential or non-sequential. It then stalls the bus for the configured
// number of wait cycles. It also flags illegal accesses (writes to read-only
// regions, reserved size encoding) with a one-cycle abort pulse.
module mem_wait_ctrl #(
    parameter int unsigned EWRAM_WAIT = 2,
    parameter int unsigned IO_WAIT    = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [1:0]  size,
    input  logic        write,
    input  logic        mreq,
    input  logic [15:0] waitcnt,
    output logic        pause,
    output logic        abort,
    output logic        seq
);

    typedef enum logic [1:0] {
        MEM_SIZE_BYTE = 2'd0,
        MEM_SIZE_HALF = 2'd1,
        MEM_SIZE_WORD = 2'd2,
        MEM_SIZE_RESR = 2'd3
    } mem_size_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    typedef enum logic [2:0] {
        RG_BIOS  = 3'd0,
        RG_EWRAM = 3'd1,
        RG_IWRAM = 3'd2,
        RG_IO    = 3'd3,
        RG_WS0   = 3'd4,
        RG_WS1   = 3'd5,
        RG_WS2   = 3'd6,
        RG_SRAM  = 3'd7
    } region_e;

    localparam logic [3:0] EWRAM_W = 4'(EWRAM_WAIT);
    localparam logic [3:0] IO_W    = 4'(IO_WAIT);

    // Non-sequential wait table shared by the cartridge ROM/SRAM fields.
    function automatic logic [3:0] n_wait(input logic [1:0] f);
        logic [3:0] w;
        case (f)
            2'd0:    w = 4'd4;
            2'd1:    w = 4'd3;
            2'd2:    w = 4'd2;
            default: w = 4'd8;
        endcase
        return w;
    endfunction

    state_e      r_state;
    state_e      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic        r_prev_valid;
    logic [31:0] r_prev_addr;
    logic        r_abort;
    logic        r_seq;

    mem_size_e   w_size;
    region_e     w_region;
    logic        w_accept;
    logic        w_resr;
    logic        w_illegal_wr;
    logic        w_err;
    logic [31:0] w_step;
    logic        w_is_seq;
    logic [3:0]  w_n;
    logic [3:0]  w_s;
    logic [3:0]  w_wait;
    logic        w_unused;

    assign w_unused = ^waitcnt[15:11];

    assign pause    = (r_state == ST_WAIT);
    assign abort    = r_abort;
    assign seq      = r_seq;

    assign w_size   = mem_size_e'(size);
    assign w_accept = mreq & ~pause;
    assign w_resr   = (w_size == MEM_SIZE_RESR);
    assign w_step   = 32'd1 << size;

    // Region decode from address bits [27:24].
    always_comb begin
        w_region = RG_BIOS;
        case (addr[27:24])
            4'h0, 4'h1:             w_region = RG_BIOS;
            4'h2:                   w_region = RG_EWRAM;
            4'h3:                   w_region = RG_IWRAM;
            4'h4, 4'h5, 4'h6, 4'h7: w_region = RG_IO;
            4'h8, 4'h9:             w_region = RG_WS0;
            4'hA, 4'hB:             w_region = RG_WS1;
            4'hC, 4'hD:             w_region = RG_WS2;
            default:                w_region = RG_SRAM;
        endcase
    end

    assign w_illegal_wr = write & ((w_region == RG_BIOS) || (w_region == RG_WS0) ||
                                   (w_region == RG_WS1)  || (w_region == RG_WS2));
    assign w_err        = w_resr | w_illegal_wr;

    // A 128 KiB boundary restarts the cartridge burst, so it is never sequential.
    assign w_is_seq = r_prev_valid &&
                      (r_prev_addr[27:24] == addr[27:24]) &&
                      (addr == r_prev_addr + w_step) &&
                      (addr[16:0] != '0);

    // Per-region N and S wait counts from the live waitcnt value.
    always_comb begin
        w_n = '0;
        w_s = '0;
        case (w_region)
            RG_EWRAM: begin
                w_n = EWRAM_W;
                w_s = EWRAM_W;
            end
            RG_IO: begin
                w_n = IO_W;
                w_s = IO_W;
            end
            RG_WS0: begin
                w_n = n_wait(waitcnt[3:2]);
                w_s = waitcnt[4] ? 4'd1 : 4'd2;
            end
            RG_WS1: begin
                w_n = n_wait(waitcnt[6:5]);
                w_s = waitcnt[7] ? 4'd1 : 4'd4;
            end
            RG_WS2: begin
                w_n = n_wait(waitcnt[9:8]);
                w_s = waitcnt[10] ? 4'd1 : 4'd8;
            end
            RG_SRAM: begin
                w_n = n_wait(waitcnt[1:0]);
                w_s = n_wait(waitcnt[1:0]);
            end
            default: begin
                w_n = '0;
                w_s = '0;
            end
        endcase
    end

    assign w_wait = w_err ? '0 : (w_is_seq ? w_s : w_n);

    // State and wait-counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic: load the wait on acceptance, count down while stalled.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && (w_wait != '0)) begin
                    w_state_nxt = ST_WAIT;
                    w_cnt_nxt   = w_wait;
                end
            end
            ST_WAIT: begin
                if (r_cnt <= 4'd1) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Previous-access tracking used for sequential classification.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_valid <= 1'b0;
            r_prev_addr  <= '0;
        end else if (w_accept) begin
            if (w_resr) begin
                r_prev_valid <= r_prev_valid;
            end else if (w_illegal_wr) begin
                r_prev_valid <= 1'b0;
            end else begin
                r_prev_valid <= 1'b1;
                r_prev_addr  <= addr;
            end
        end else if (!pause && !mreq) begin
            r_prev_valid <= 1'b0;
        end
    end

    // Registered one-cycle abort pulse and sequential flag of the last acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_abort <= 1'b0;
            r_seq   <= 1'b0;
        end else begin
            r_abort <= w_accept & w_err;
            if (w_accept) begin
                r_seq <= w_err ? 1'b0 : w_is_seq;
            end
        end
    end

endmodule

// File: tb/tb_mem_wait_ctrl.sv
// Self-checking bench for mem_wait_ctrl: table of accesses with hand-derived
// wait/seq/abort expectations plus hand-written multi-cycle corner cases.
module tb_mem_wait_ctrl;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_R = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr = '0;
    logic [1:0]  size = '0;
    logic        write = 1'b0;
    logic        mreq = 1'b0;
    logic [15:0] waitcnt = '0;
    logic        pause;
    logic        abort;
    logic        seq;

    mem_wait_ctrl #(
        .EWRAM_WAIT(2),
        .IO_WAIT   (1)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .addr   (addr),
        .size   (size),
        .write  (write),
        .mreq   (mreq),
        .waitcnt(waitcnt),
        .pause  (pause),
        .abort  (abort),
        .seq    (seq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [1:0]  sz;
        logic        wr;
        logic [15:0] wc;
        int unsigned ew;
        logic        es;
        logic        ea;
    } vec_t;

    typedef struct {
        logic  p;
        logic  a;
        logic  s;
        string tag;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    logic last_seq = 1'b0;
    vec_t vecs[29];

    task automatic chk(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0b expected=%0b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_pop();
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk({e.tag, ".pause"}, pause, e.p);
            chk({e.tag, ".abort"}, abort, e.a);
            chk({e.tag, ".seq"},   seq,   e.s);
        end
    endtask

    // One bus cycle: check the outputs due now, then drive the next inputs and
    // queue the outputs expected one cycle later.
    task automatic step(input logic m, input logic [31:0] a, input logic [1:0] sz,
                        input logic wr, input logic [15:0] wc,
                        input logic ep, input logic ea, input logic es, input string tag);
        exp_t e;
        @(negedge clk);
        chk_pop();
        mreq = m; addr = a; size = sz; write = wr; waitcnt = wc;
        e.p = ep; e.a = ea; e.s = es; e.tag = tag;
        q.push_back(e);
    endtask

    // Wait cycles: the request stays on the bus (ignored) with waitcnt = wc.
    task automatic fill(input int unsigned ew, input logic es, input logic [15:0] wc,
                        input string tag);
        for (int unsigned j = 1; j <= ew; j++)
            step(1'b1, addr, size, write, wc, (j < ew), 1'b0, es,
                 $sformatf("%s.w%0d", tag, j));
    endtask

    task automatic access(input logic [31:0] a, input logic [1:0] sz, input logic wr,
                          input logic [15:0] wc, input int unsigned ew, input logic es,
                          input logic ea, input logic [15:0] wcf, input string tag);
        step(1'b1, a, sz, wr, wc, (ew > 0), ea, es, tag);
        fill(ew, es, wcf, tag);
        last_seq = es;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned j = 0; j < n; j++)
            step(1'b0, '0, '0, 1'b0, waitcnt, 1'b0, 1'b0, last_seq, "idle");
    endtask

    function automatic vec_t mk(input logic [31:0] a, input logic [1:0] sz, input logic wr,
                                input logic [15:0] wc, input int unsigned ew,
                                input logic es, input logic ea);
        vec_t v;
        v.a = a; v.sz = sz; v.wr = wr; v.wc = wc; v.ew = ew; v.es = es; v.ea = ea;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //                 addr          sz    wr    wc       W  seq abort
        vecs[0]  = mk(32'h0000_0000, SZ_W, 1'b0, 16'h0000, 0, 1'b0, 1'b0);
        vecs[1]  = mk(32'h0000_0004, SZ_W, 1'b0, 16'h0000, 0, 1'b1, 1'b0);
        vecs[2]  = mk(32'h0200_0000, SZ_W, 1'b0, 16'h0000, 2, 1'b0, 1'b0);
        vecs[3]  = mk(32'h0200_0004, SZ_W, 1'b0, 16'h0000, 2, 1'b1, 1'b0);
        vecs[4]  = mk(32'h0300_0010, SZ_H, 1'b0, 16'h0000, 0, 1'b0, 1'b0);
        vecs[5]  = mk(32'h0300_0012, SZ_H, 1'b0, 16'h0000, 0, 1'b1, 1'b0);
        vecs[6]  = mk(32'h0400_0000, SZ_W, 1'b1, 16'h0000, 1, 1'b0, 1'b0);
        vecs[7]  = mk(32'h0800_0000, SZ_W, 1'b0, 16'h0018, 2, 1'b0, 1'b0);
        vecs[8]  = mk(32'h0800_0004, SZ_W, 1'b0, 16'h0018, 1, 1'b1, 1'b0);
        vecs[9]  = mk(32'h0800_0008, SZ_W, 1'b0, 16'h0000, 2, 1'b1, 1'b0);
        vecs[10] = mk(32'h0801_FFFC, SZ_W, 1'b0, 16'h0000, 4, 1'b0, 1'b0);
        vecs[11] = mk(32'h0802_0000, SZ_W, 1'b0, 16'h0000, 4, 1'b0, 1'b0);
        vecs[12] = mk(32'h0A00_0000, SZ_H, 1'b0, 16'h0040, 2, 1'b0, 1'b0);
        vecs[13] = mk(32'h0A00_0002, SZ_H, 1'b0, 16'h0040, 4, 1'b1, 1'b0);
        vecs[14] = mk(32'h0A00_0004, SZ_H, 1'b0, 16'h00C0, 1, 1'b1, 1'b0);
        vecs[15] = mk(32'h0C00_0000, SZ_B, 1'b0, 16'h0100, 3, 1'b0, 1'b0);
        vecs[16] = mk(32'h0C00_0001, SZ_B, 1'b0, 16'h0100, 8, 1'b1, 1'b0);
        vecs[17] = mk(32'h0C00_0002, SZ_B, 1'b0, 16'h0500, 1, 1'b1, 1'b0);
        vecs[18] = mk(32'h0E00_0000, SZ_B, 1'b0, 16'h0003, 8, 1'b0, 1'b0);
        vecs[19] = mk(32'h0E00_0001, SZ_B, 1'b0, 16'h0002, 2, 1'b1, 1'b0);
        vecs[20] = mk(32'h0E00_0002, SZ_B, 1'b1, 16'h0001, 3, 1'b1, 1'b0);
        vecs[21] = mk(32'h0800_0000, SZ_W, 1'b1, 16'h0000, 0, 1'b0, 1'b1);
        vecs[22] = mk(32'h0800_0004, SZ_W, 1'b0, 16'h0018, 2, 1'b0, 1'b0);
        vecs[23] = mk(32'h0800_0008, SZ_R, 1'b0, 16'h0018, 0, 1'b0, 1'b1);
        vecs[24] = mk(32'h0800_0008, SZ_W, 1'b0, 16'h0018, 1, 1'b1, 1'b0);
        vecs[25] = mk(32'h0000_0100, SZ_W, 1'b1, 16'h0000, 0, 1'b0, 1'b1);
        vecs[26] = mk(32'h0300_0000, SZ_W, 1'b0, 16'h0000, 0, 1'b0, 1'b0);
        vecs[27] = mk(32'h0300_0004, SZ_W, 1'b0, 16'h0000, 0, 1'b1, 1'b0);
        vecs[28] = mk(32'h0300_0008, SZ_W, 1'b0, 16'h0000, 0, 1'b1, 1'b0);

        // Reset state.
        @(posedge clk);
        #1;
        chk("reset.pause", pause, 1'b0);
        chk("reset.abort", abort, 1'b0);
        chk("reset.seq",   seq,   1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 29; i++)
            access(vecs[i].a, vecs[i].sz, vecs[i].wr, vecs[i].wc, vecs[i].ew,
                   vecs[i].es, vecs[i].ea, vecs[i].wc, $sformatf("v%0d", i));

        // An idle bus cycle breaks the sequential chain.
        idle(1);
        access(32'h0300_000C, SZ_W, 1'b0, 16'h0000, 0, 1'b0, 1'b0, 16'h0000, "gap");

        // waitcnt changing during a wait leaves the loaded count untouched.
        idle(1);
        access(32'h0800_0000, SZ_W, 1'b0, 16'h000C, 8, 1'b0, 1'b0, 16'h0008, "wcchg");
        access(32'h0800_0004, SZ_W, 1'b0, 16'h0008, 2, 1'b1, 1'b0, 16'h0008, "wcchg_s");

        // Reset during wait cycle 3 of an 8-cycle WS2 N access.
        idle(1);
        step(1'b1, 32'h0C00_0000, SZ_W, 1'b0, 16'h0700, 1'b1, 1'b0, 1'b0, "rst.acc");
        step(1'b1, 32'h0C00_0004, SZ_W, 1'b0, 16'h0700, 1'b1, 1'b0, 1'b0, "rst.w1");
        step(1'b1, 32'h0C00_0004, SZ_W, 1'b0, 16'h0700, 1'b1, 1'b0, 1'b0, "rst.w2");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst.pause", pause, 1'b0);
        chk("midrst.abort", abort, 1'b0);
        chk("midrst.seq",   seq,   1'b0);
        q.delete();
        repeat (2) begin
            @(negedge clk);
            chk("inrst.pause", pause, 1'b0);
        end
        // Release with the +4 request already on the bus: it must be N (8 waits).
        rst_n = 1'b1;
        begin
            exp_t e;
            e.p = 1'b1; e.a = 1'b0; e.s = 1'b0; e.tag = "postrst";
            q.push_back(e);
        end
        fill(8, 1'b0, 16'h0700, "postrst");
        last_seq = 1'b0;
        idle(2);
        @(negedge clk);
        chk_pop();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
